// File: rtl/add_scheduler_pkg.sv
// Shared state encoding and sizing helper for the round-robin add/sub scheduler.
package add_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    function automatic int unsigned calc_id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_scheduler_if.sv
// Requester and response channels of the add/sub scheduler.
interface add_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ID_W    = add_sched_pkg::calc_id_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_result;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_carry;
    logic                     rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_carry, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id, rsp_carry, rsp_ovf
    );

endinterface

// File: rtl/add_scheduler_rr_picker.sv
// Combinational round-robin winner search starting at ptr_i and wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        int idx;
        gnt_idx_o = '0;
        any_o     = |req_i;
        // Walk farthest-first so the requester closest to ptr_i is written last and wins.
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            idx = int'(ptr_i) + off;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (req_i[ID_W'(idx)]) begin
                gnt_idx_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/add_scheduler.sv
// Shares one add/sub datapath among NUM_REQ requesters: grant, execute, then hold the
// tagged result until the consumer accepts it.
module add_scheduler
    import add_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 64
) (
    input logic            clk,
    input logic            rst,
    add_scheduler_if.slave bus
);

    localparam int unsigned ID_W = calc_id_w(NUM_REQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   op_id_q;
    logic [WIDTH-1:0]  op_a_q, op_b_q;
    logic              op_sub_q;
    logic [WIDTH-1:0]  rsp_result_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_carry_q, rsp_ovf_q;

    logic [ID_W-1:0]   gnt_idx;
    logic              any_req;
    logic              grant;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH:0]    sum;
    logic              ovf;

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_picker (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_idx_o(gnt_idx),
        .any_o    (any_req)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant         = 1'b0;
        bus.req_ready = '0;
        unique case (state_q)
            StIdle: grant = any_req;
            StExec: state_d = StResp;
            StResp: begin
                // Response retires this cycle; a pending request is granted alongside it.
                if (bus.rsp_ready) begin
                    grant   = any_req;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant) begin
            state_d                = StExec;
            bus.req_ready[gnt_idx] = 1'b1;
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_comb begin
        b_eff = op_sub_q ? ~op_b_q : op_b_q;
        sum   = {1'b0, op_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub_q};
        ovf   = (op_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            op_id_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sub_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (grant) begin
                op_id_q  <= gnt_idx;
                op_a_q   <= bus.req_a[int'(gnt_idx) * WIDTH +: WIDTH];
                op_b_q   <= bus.req_b[int'(gnt_idx) * WIDTH +: WIDTH];
                op_sub_q <= bus.req_sub[gnt_idx];
            end
            if (state_q == StExec) begin
                rsp_result_q <= sum[WIDTH-1:0];
                rsp_carry_q  <= sum[WIDTH];
                rsp_ovf_q    <= ovf;
                rsp_id_q     <= op_id_q;
            end
        end
    end

    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_ovf    = rsp_ovf_q;

endmodule
